// File: rtl/matrix_sched_pkg.sv
// Shared types and default sizes for the matrix job scheduler.
package matrix_sched_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_AW   = 16;
   localparam int DEF_CW   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RETIRE = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic [DEF_AW-1:0] matAddr;
      logic [DEF_AW-1:0] vecAddr;
      logic [DEF_AW-1:0] outAddr;
      logic [DEF_CW-1:0] count;
   } job_desc_t;

endpackage

// File: rtl/matrix_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   int cand;

   // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr) + i) % NREQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/matrix_job_scheduler.sv
// Shares one matrix processor among NREQ requesters: round-robin grant, launch, wait, retire.
// Optional watchdog abort is enabled by defining MATRIX_SCHED_WATCHDOG_EN.
module matrix_job_scheduler
   import matrix_sched_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int AW      = DEF_AW,
   parameter int CW      = DEF_CW,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*AW-1:0]      req_mat_addr,
   input  logic [NREQ*AW-1:0]      req_vec_addr,
   input  logic [NREQ*AW-1:0]      req_out_addr,
   input  logic [NREQ*CW-1:0]      req_count,
   output logic [NREQ-1:0]         done_valid,
   output logic                    done_err,
   output logic                    mp_start,
   output logic [AW-1:0]           mp_mat_addr,
   output logic [AW-1:0]           mp_vec_addr,
   output logic [AW-1:0]           mp_out_addr,
   output logic [CW-1:0]           mp_count,
   input  logic                    mp_done,
   output logic                    mp_abort,
   output logic                    sched_busy,
   output logic [$clog2(NREQ)-1:0] cur_owner
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : gBadParams
      $error("matrix_job_scheduler: NREQ must be 2..8 and TIMEOUT at least 2");
   end

   sched_state_t    state, nextState;
   logic [IW-1:0]   ptr, owner, arbIdx;
   logic [NREQ-1:0] arbGrant;
   logic            arbAny, accept, timeoutHit, abortFlag;
   logic [AW-1:0]   matQ, vecQ, outQ;
   logic [CW-1:0]   countQ, selCount;

   rr_arbiter #(.NREQ(NREQ)) uArb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arbGrant),
      .idx   (arbIdx),
      .any   (arbAny)
   );

   assign selCount = req_count[arbIdx*CW +: CW];

   always_comb begin
      nextState = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (arbAny) begin
               accept    = 1'b1;
               nextState = (selCount != '0) ? LAUNCH : RETIRE;
            end
         end
         LAUNCH:  nextState = WAIT;
         WAIT:    if (mp_done || timeoutHit) nextState = RETIRE;
         RETIRE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         matQ   <= '0;
         vecQ   <= '0;
         outQ   <= '0;
         countQ <= '0;
      end else begin
         state <= nextState;
         if (accept) begin
            owner  <= arbIdx;
            matQ   <= req_mat_addr[arbIdx*AW +: AW];
            vecQ   <= req_vec_addr[arbIdx*AW +: AW];
            outQ   <= req_out_addr[arbIdx*AW +: AW];
            countQ <= selCount;
         end
         if (state == RETIRE) ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
   end

`ifdef MATRIX_SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT) + 1;

   logic [WDW-1:0] wdCnt;
   logic           abortQ;

   // mp_done in the same cycle as the limit takes priority over the abort.
   assign timeoutHit = (state == WAIT) && !mp_done && (wdCnt == WDW'(TIMEOUT - 1));
   assign abortFlag  = abortQ;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wdCnt  <= '0;
         abortQ <= 1'b0;
      end else begin
         if (state == LAUNCH)    wdCnt <= '0;
         else if (state == WAIT) wdCnt <= wdCnt + 1'b1;
         if (accept)             abortQ <= 1'b0;
         else if (timeoutHit)    abortQ <= 1'b1;
      end
   end
`else
   assign timeoutHit = 1'b0;
   assign abortFlag  = 1'b0;
`endif

   // Every output is forced low while rst_n is asserted, not just after the reset edge.
   assign req_ready   = (rst_n && state == IDLE) ? arbGrant : '0;
   assign done_valid  = (rst_n && state == RETIRE) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : '0;
   assign done_err    = rst_n && (state == RETIRE) && abortFlag;
   assign mp_start    = rst_n && (state == LAUNCH);
   assign mp_abort    = rst_n && timeoutHit;
   assign sched_busy  = rst_n && (state != IDLE);
   assign cur_owner   = rst_n ? owner  : '0;
   assign mp_mat_addr = rst_n ? matQ   : '0;
   assign mp_vec_addr = rst_n ? vecQ   : '0;
   assign mp_out_addr = rst_n ? outQ   : '0;
   assign mp_count    = rst_n ? countQ : '0;

endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Directed self-checking bench for matrix_job_scheduler (NREQ=4, AW=16, CW=8, TIMEOUT=16).
module tb_matrix_job_scheduler;
   import matrix_sched_pkg::*;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int CW   = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_mat_addr, req_vec_addr, req_out_addr;
   logic [NREQ*CW-1:0] req_count;
   logic [NREQ-1:0]    done_valid;
   logic               done_err, mp_start, mp_done, mp_abort, sched_busy;
   logic [AW-1:0]      mp_mat_addr, mp_vec_addr, mp_out_addr;
   logic [CW-1:0]      mp_count;
   logic [1:0]         cur_owner;

   int checks   = 0;
   int failures = 0;

   matrix_job_scheduler #(.NREQ(NREQ), .AW(AW), .CW(CW), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_mat_addr (req_mat_addr),
      .req_vec_addr (req_vec_addr),
      .req_out_addr (req_out_addr),
      .req_count    (req_count),
      .done_valid   (done_valid),
      .done_err     (done_err),
      .mp_start     (mp_start),
      .mp_mat_addr  (mp_mat_addr),
      .mp_vec_addr  (mp_vec_addr),
      .mp_out_addr  (mp_out_addr),
      .mp_count     (mp_count),
      .mp_done      (mp_done),
      .mp_abort     (mp_abort),
      .sched_busy   (sched_busy),
      .cur_owner    (cur_owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic job_desc_t mkDesc(input logic [15:0] m, input logic [15:0] v,
                                        input logic [15:0] o, input logic [7:0] c);
      job_desc_t d;
      d.matAddr = m;
      d.vecAddr = v;
      d.outAddr = o;
      d.count   = c;
      return d;
   endfunction

   task automatic setJob(input int i, input logic v, input job_desc_t d);
      req_valid[i]              = v;
      req_mat_addr[i*AW +: AW]  = d.matAddr;
      req_vec_addr[i*AW +: AW]  = d.vecAddr;
      req_out_addr[i*AW +: AW]  = d.outAddr;
      req_count[i*CW +: CW]     = d.count;
   endtask

   job_desc_t jobs [NREQ];

   initial begin
      rst_n        = 1'b0;
      req_valid    = '0;
      req_mat_addr = '0;
      req_vec_addr = '0;
      req_out_addr = '0;
      req_count    = '0;
      mp_done      = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_busy",  32'(sched_busy), 32'd0);
      check("rst_ready", 32'(req_ready),  32'd0);
      check("rst_done",  32'(done_valid), 32'd0);
      check("rst_start", 32'(mp_start),   32'd0);
      check("rst_abort", 32'(mp_abort),   32'd0);
      check("rst_owner", 32'(cur_owner),  32'd0);

      // Single job from requester 2, mp_done 40 cycles after accept
      rst_n = 1'b1;
      setJob(2, 1'b1, mkDesc(16'h0100, 16'h0200, 16'h0300, 8'd8));
      #1;
      check("single_ready_T", 32'(req_ready), 32'b0100);
      tick();                                          // T+1
      setJob(2, 1'b0, mkDesc(16'hDEAD, 16'hBEEF, 16'hCAFE, 8'd99));
      #1;
      check("single_start", 32'(mp_start),    32'd1);
      check("single_mat",   32'(mp_mat_addr), 32'h0100);
      check("single_vec",   32'(mp_vec_addr), 32'h0200);
      check("single_out",   32'(mp_out_addr), 32'h0300);
      check("single_cnt",   32'(mp_count),    32'd8);
      check("single_owner", 32'(cur_owner),   32'd2);
      check("single_ready_busy", 32'(req_ready), 32'd0);
      tick();                                          // T+2
      check("single_start_once", 32'(mp_start), 32'd0);
      repeat (38) tick();                              // T+40
      check("single_wait_busy", 32'(sched_busy), 32'd1);
      check("single_wait_done", 32'(done_valid), 32'd0);
      mp_done = 1'b1;
      tick();                                          // T+41
      mp_done = 1'b0;
      check("single_done_valid", 32'(done_valid),  32'b0100);
      check("single_done_err",   32'(done_err),    32'd0);
      check("single_mat_held",   32'(mp_mat_addr), 32'h0100);
      tick();
      check("single_idle", 32'(sched_busy), 32'd0);
      check("single_done_clr", 32'(done_valid), 32'd0);

      // Contention: all four valid after a fresh reset, expect 0,1,2,3,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         jobs[i] = mkDesc(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 8'd1);
         setJob(i, 1'b1, jobs[i]);
      end
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % NREQ)));
         tick();                                       // LAUNCH
         check($sformatf("rr_owner_%0d", k), 32'(cur_owner),   32'(k % NREQ));
         check($sformatf("rr_mat_%0d", k),   32'(mp_mat_addr), 32'(jobs[k % NREQ].matAddr));
         tick();                                       // WAIT
         mp_done = 1'b1;
         tick();                                       // RETIRE
         mp_done = 1'b0;
         check($sformatf("rr_done_%0d", k), 32'(done_valid), 32'(1 << (k % NREQ)));
         tick();                                       // IDLE
      end
      req_valid = '0;

      // Zero-count job from requester 1 (pointer is now 1)
      setJob(1, 1'b1, mkDesc(16'h0500, 16'h0600, 16'h0700, 8'd0));
      #1;
      check("zero_ready", 32'(req_ready), 32'b0010);
      tick();                                          // T+1
      req_valid = '0;
      check("zero_done",  32'(done_valid), 32'b0010);
      check("zero_start", 32'(mp_start),   32'd0);
      check("zero_err",   32'(done_err),   32'd0);
      tick();                                          // T+2
      check("zero_idle",   32'(sched_busy), 32'd0);
      check("zero_start2", 32'(mp_start),   32'd0);

      // Spurious mp_done in IDLE, then in LAUNCH
      mp_done = 1'b1;
      tick();
      mp_done = 1'b0;
      check("spur_idle_busy", 32'(sched_busy), 32'd0);
      check("spur_idle_done", 32'(done_valid), 32'd0);
      setJob(0, 1'b1, mkDesc(16'h0A00, 16'h0B00, 16'h0C00, 8'd5));
      #1;
      check("spur_ready", 32'(req_ready), 32'b0001);
      tick();                                          // LAUNCH
      req_valid = '0;
      mp_done   = 1'b1;
      check("spur_launch_start", 32'(mp_start), 32'd1);
      tick();                                          // WAIT, done ignored
      mp_done = 1'b0;
      check("spur_launch_busy", 32'(sched_busy), 32'd1);
      check("spur_launch_done", 32'(done_valid), 32'd0);
      tick();
      check("spur_wait_hold", 32'(done_valid), 32'd0);
      mp_done = 1'b1;
      tick();                                          // RETIRE
      mp_done = 1'b0;
      check("spur_retire", 32'(done_valid), 32'b0001);
      tick();

      // Reset while in WAIT drops the job; pointer returns to 0
      setJob(2, 1'b1, mkDesc(16'h0D00, 16'h0E00, 16'h0F00, 8'd3));
      tick();                                          // LAUNCH
      req_valid = '0;
      tick();                                          // WAIT
      rst_n   = 1'b0;
      mp_done = 1'b1;
      #1;
      check("rstw_busy_comb",  32'(sched_busy),  32'd0);
      check("rstw_mat_comb",   32'(mp_mat_addr), 32'd0);
      check("rstw_owner_comb", 32'(cur_owner),   32'd0);
      check("rstw_done_comb",  32'(done_valid),  32'd0);
      tick();
      rst_n   = 1'b1;
      mp_done = 1'b0;
      check("rstw_done_after", 32'(done_valid), 32'd0);
      check("rstw_idle",       32'(sched_busy), 32'd0);
      setJob(0, 1'b1, mkDesc(16'h0011, 16'h0022, 16'h0033, 8'd0));
      setJob(3, 1'b1, mkDesc(16'h4100, 16'h4200, 16'h4300, 8'd2));
      #1;
      check("rstw_ptr_zero", 32'(req_ready), 32'b0001);
      tick();                                          // RETIRE for zero-count job 0
      req_valid[0] = 1'b0;
      check("rstw_job0_done", 32'(done_valid), 32'b0001);
      tick();                                          // IDLE, pointer 1
      check("rstw_req3_ready", 32'(req_ready), 32'b1000);
      tick();                                          // LAUNCH
      req_valid = '0;
      check("rstw_req3_mat", 32'(mp_mat_addr), 32'h4100);
      check("rstw_req3_cnt", 32'(mp_count),    32'd2);
      tick();
      mp_done = 1'b1;
      tick();
      mp_done = 1'b0;
      check("rstw_req3_done", 32'(done_valid), 32'b1000);
      check("rstw_req3_err",  32'(done_err),   32'd0);
      tick();

`ifdef MATRIX_SCHED_WATCHDOG_EN
      // Watchdog: no mp_done, abort 16 cycles after LAUNCH
      setJob(1, 1'b1, mkDesc(16'h0123, 16'h0456, 16'h0789, 8'd4));
      tick();                                          // LAUNCH (L)
      req_valid = '0;
      repeat (15) tick();                              // L+15
      check("wd_abort_early", 32'(mp_abort), 32'd0);
      tick();                                          // L+16
      check("wd_abort",       32'(mp_abort),   32'd1);
      check("wd_abort_nodone", 32'(done_valid), 32'd0);
      tick();                                          // RETIRE
      check("wd_done_valid", 32'(done_valid), 32'b0010);
      check("wd_done_err",   32'(done_err),   32'd1);
      check("wd_abort_clr",  32'(mp_abort),   32'd0);
      tick();
      check("wd_idle", 32'(sched_busy), 32'd0);
`else
      // Without the watchdog a long WAIT never aborts
      setJob(1, 1'b1, mkDesc(16'h0123, 16'h0456, 16'h0789, 8'd4));
      tick();
      req_valid = '0;
      repeat (40) tick();
      check("nowd_abort", 32'(mp_abort),   32'd0);
      check("nowd_busy",  32'(sched_busy), 32'd1);
      mp_done = 1'b1;
      tick();
      mp_done = 1'b0;
      check("nowd_done", 32'(done_valid), 32'b0010);
      check("nowd_err",  32'(done_err),   32'd0);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_job_scheduler.md
Name: matrix_job_scheduler

Overview:
- Shares one matrix processor (4x4 matrix load, 4-vector load, FMA processing) among NREQ requesters (shader cores / command front-end).
- Round-robin arbitrates job descriptors, latches the winner's descriptor and drives the processor's configuration and start.
- Waits for the processor to complete, then returns a per-requester completion pulse.
- Sits between the core request fabric and the matrix processor controller/datapath.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- AW, 16: address width of matrix, vector and output base addresses.
- CW, 8: work-item count width.
- TIMEOUT, 1024: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_mat_addr  in  NREQ*AW  flattened matrix base address; requester i occupies slice [i*AW +: AW].
- req_vec_addr  in  NREQ*AW  flattened vector base address.
- req_out_addr  in  NREQ*AW  flattened output base address.
- req_count  in  NREQ*CW  flattened work-item count.
- done_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- done_err  out  1  qualifies done_valid: job was aborted.
- mp_start  out  1  one-cycle start pulse to the processor.
- mp_mat_addr, mp_vec_addr, mp_out_addr  out  AW  latched job configuration.
- mp_count  out  CW  latched work-item count.
- mp_done  in  1  processor completion pulse (processor returned to idle).
- mp_abort  out  1  abort pulse; tied 0 without the optional feature.
- sched_busy  out  1  high whenever state != IDLE.
- cur_owner  out  $clog2(NREQ)  index of the job owner.

Behaviour:
- Reset (sync, rst_n low at posedge):
  - All outputs go to 0; state goes to IDLE; round-robin pointer goes to 0.
  - An in-flight job is dropped with no done pulse.
  - Reset is held 0 combinationally while rst_n is low.
- States: IDLE, LAUNCH, WAIT, RETIRE.
- IDLE:
  - If any req_valid is set, the grant goes to the first valid index at or after the pointer, wrapping modulo NREQ.
  - req_ready[winner] is 1 combinationally in that same cycle; accept = valid & ready.
  - On accept, latch the four descriptor fields and the owner.
  - Next state is LAUNCH if count != 0, else RETIRE.
  - No request: stay in IDLE, req_ready = 0.
- LAUNCH:
  - mp_start = 1 for exactly this cycle; next state is WAIT.
  - mp_done is ignored in this cycle.
- WAIT:
  - mp_* outputs are held stable from LAUNCH until RETIRE.
  - On mp_done, go to RETIRE.
  - mp_done is sampled only in WAIT; it is ignored in every other state.
- RETIRE:
  - done_valid[owner] = 1 for one cycle; done_err = 0, or the abort flag under the feature.
  - Pointer becomes (owner+1) mod NREQ; next state is IDLE.
- req_ready is 0 in every state other than IDLE, so requests hold until granted.
- Latency:
  - Accept at cycle T.
  - mp_start at T+1.
  - done_valid at the cycle after mp_done is seen.
  - Zero-count job: done_valid at T+1 and mp_start is never asserted.
- Fairness: a continuously-valid requester waits at most NREQ-1 other jobs.
- Simultaneous requests: exactly one winner per IDLE cycle; the others are not accepted.
- The pointer wraps from NREQ-1 to 0.
- Descriptor changes by a requester after accept have no effect.

Optional Feature:
- MATRIX_SCHED_WATCHDOG_EN defined:
  - A cycle counter of width $clog2(TIMEOUT)+1 clears on LAUNCH and increments in WAIT.
  - If the counter reaches TIMEOUT-1 without mp_done: mp_abort = 1 for one cycle, set the abort flag, go to RETIRE.
  - RETIRE then pulses done_valid[owner] with done_err = 1.
  - mp_done and timeout in the same cycle: mp_done wins, done_err = 0.
- Undefined: no counter; mp_abort and done_err are constant 0; WAIT waits indefinitely.

Decomposition:
- Package matrix_sched_pkg: state enum (2-bit), descriptor struct (mat, vec, out addresses; count), and the NREQ/AW/CW defaults as localparams.
- Sub-module rr_arbiter (NREQ parameter):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.

Test Plan:
- Single job: req 2 valid, count=8, mat=0x0100, vec=0x0200, out=0x0300 → ready[2] at T; mp_start at T+1 with those values; mp_done at T+40 → done_valid=0b0100 at T+41, done_err=0.
- Contention: all 4 valid from reset → grant order 0,1,2,3,0; each done_valid one-hot matches the owner.
- Zero count: req 1 count=0 → accepted, mp_start never high, done_valid[1] at T+1, back in IDLE at T+2.
- Spurious mp_done in IDLE and in LAUNCH → no state change, no done_valid.
- Reset in WAIT: rst_n low for 1 cycle → all outputs 0, no done pulse, pointer 0; the next job from req 3 is granted normally.
- Watchdog (feature on, TIMEOUT=16): no mp_done → mp_abort pulse 16 cycles after LAUNCH, then done_valid with done_err=1.
